// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that sequences one cache transaction at a time.
// Includes a watchdog that aborts with err when the cache never signals odv.
module mem_arbiter #(
  parameter int d_width   = 4,
  parameter int a_width   = 8,
  parameter int tmo_width = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               req0,
  input  logic [a_width-1:0] addr0,
  input  logic [d_width-1:0] wdata0,
  input  logic               rw0,
  output logic               ack0,
  input  logic               req1,
  input  logic [a_width-1:0] addr1,
  input  logic [d_width-1:0] wdata1,
  input  logic               rw1,
  output logic               ack1,
  output logic [d_width-1:0] rdata,
  output logic               err,
  output logic               busy,
  output logic [a_width-1:0] c_addr,
  output logic [d_width-1:0] c_wdata,
  output logic               c_rw,
  output logic               c_ce,
  input  logic [d_width-1:0] c_rdata,
  input  logic               c_odv
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t               state;
  logic                 prio;
  logic                 gnt;
  logic                 pick;
  logic [tmo_width-1:0] wdog;
  logic [tmo_width-1:0] wdog_nxt;

  always_comb begin
    pick     = (req0 && req1) ? prio : req1;
    wdog_nxt = wdog + tmo_width'(1);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      prio    <= 1'b0;
      gnt     <= 1'b0;
      wdog    <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      c_ce    <= 1'b0;
      c_rw    <= 1'b1;
      c_addr  <= '0;
      c_wdata <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt  <= pick;
            c_ce <= 1'b1;
            busy <= 1'b1;
            wdog <= '0;
            if (pick) begin
              c_addr  <= addr1;
              c_wdata <= wdata1;
              c_rw    <= rw1;
            end else begin
              c_addr  <= addr0;
              c_wdata <= wdata0;
              c_rw    <= rw0;
            end
            state <= BUSY;
          end
        end
        BUSY: begin
          wdog <= wdog_nxt;
          if (c_odv) begin
            if (c_rw) rdata <= c_rdata;
            c_ce  <= 1'b0;
            err   <= 1'b0;
            ack0  <= ~gnt;
            ack1  <= gnt;
            state <= ACK;
          // Test the incremented count so the abort lands after exactly
          // 2^tmo_width-1 BUSY cycles counted from the grant edge.
          end else if (wdog_nxt == '1) begin
            c_ce  <= 1'b0;
            err   <= 1'b1;
            ack0  <= ~gnt;
            ack1  <= gnt;
            state <= ACK;
          end
        end
        ACK: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          prio  <= ~gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
